hh_rate_engine: RTL and testbench

Parametrised, time-multiplexed Hodgkin-Huxley gating-rate engine. It accepts a membrane voltage and a neuron tag over a valid/ready handshake. It computes NUM_RATES rate constants (default six: alpha/beta for n, m, h) by linear interpolation into runtime-loadable per-rate LUTs, using one shared multiplier sequenced by an FSM. It sits between the neuron-state scheduler and the gating-variable integrator.

---
 rtl/hh_rate_if.sv | 37 +++
 rtl/hh_rate_engine.sv | 188 ++++++++++++++++++
 tb/tb_hh_rate_engine.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hh_rate_if.sv
// Request/result/configuration bundle for hh_rate_engine.
// The engine connects through the slave modport; its client uses the master modport.
interface hh_rate_if #(
  parameter int WIDTH         = 16,
  parameter int NUM_RATES     = 6,
  parameter int LUT_ADDR_BITS = 6,
  parameter int TAG_BITS      = 4
);
  localparam int RATE_BITS = $clog2(NUM_RATES);

  logic                               in_valid;
  logic                               in_ready;
  logic signed [WIDTH-1:0]            in_voltage;
  logic [TAG_BITS-1:0]                in_tag;

  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_RATES*WIDTH-1:0]         out_rates;
  logic [TAG_BITS-1:0]                out_tag;
  logic                               out_clamped;

  logic                               cfg_we;
  logic [RATE_BITS+LUT_ADDR_BITS-1:0] cfg_addr;
  logic [WIDTH-1:0]                   cfg_wdata;
  logic                               cfg_busy;
  logic                               cfg_err;

  modport master (
    output in_valid, in_voltage, in_tag, out_ready, cfg_we, cfg_addr, cfg_wdata,
    input  in_ready, out_valid, out_rates, out_tag, out_clamped, cfg_busy, cfg_err
  );

  modport slave (
    input  in_valid, in_voltage, in_tag, out_ready, cfg_we, cfg_addr, cfg_wdata,
    output in_ready, out_valid, out_rates, out_tag, out_clamped, cfg_busy, cfg_err
  );
endinterface

// File: rtl/hh_rate_engine.sv
// Time-multiplexed Hodgkin-Huxley gating-rate engine: per-rate LUT interpolation on one multiplier.
// Optional clamped-input counter enabled by defining HH_RATE_CLAMP_CNT_EN.
module hh_rate_engine #(
  parameter int WIDTH         = 16,
  parameter int NUM_RATES     = 6,
  parameter int LUT_ADDR_BITS = 6,
  parameter int STEP_SHIFT    = 9,
  parameter int V_MIN         = -20480,
  parameter int TAG_BITS      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  hh_rate_if.slave    bus,
  output logic [15:0] clamp_count
);

  localparam int RATE_BITS = $clog2(NUM_RATES);
  localparam int ENTRIES   = 2**LUT_ADDR_BITS;
  localparam int OFF_W     = WIDTH + 1;
  localparam int IDX_W     = OFF_W - STEP_SHIFT;
  localparam int PROD_W    = WIDTH + STEP_SHIFT + 1;

  localparam logic [LUT_ADDR_BITS-1:0] LAST_IDX  = '1;
  localparam logic [IDX_W-1:0]         LAST_RAW  = IDX_W'(ENTRIES - 1);
  localparam logic [RATE_BITS-1:0]     LAST_RATE = RATE_BITS'(NUM_RATES - 1);
  localparam logic [RATE_BITS:0]       NUM_RATES_W = (RATE_BITS+1)'(NUM_RATES);
  localparam logic signed [OFF_W-1:0]  V_MIN_S   = OFF_W'(V_MIN);
  localparam logic signed [OFF_W-1:0]  TOP_OFF   = OFF_W'((ENTRIES - 1) << STEP_SHIFT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PREP  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                 state;
  logic signed [WIDTH-1:0]    v_q;
  logic [TAG_BITS-1:0]        tag_q;
  logic [LUT_ADDR_BITS-1:0]   idx_q;
  logic [STEP_SHIFT-1:0]      frac_q;
  logic                       clamped_q;
  logic [RATE_BITS-1:0]       r_q;
  logic [WIDTH-1:0]           a_q, b_q;
  logic [NUM_RATES*WIDTH-1:0] acc_q;
  logic [NUM_RATES*WIDTH-1:0] out_rates_q;
  logic [TAG_BITS-1:0]        out_tag_q;
  logic                       out_clamped_q;
  logic                       cfg_err_q;

  logic [WIDTH-1:0] lut [NUM_RATES][ENTRIES];

  // Voltage -> (index, fraction, clamped) for the captured sample.
  logic signed [OFF_W-1:0]  offset;
  logic [IDX_W-1:0]         idx_raw;
  logic [LUT_ADDR_BITS-1:0] idx_n;
  logic [STEP_SHIFT-1:0]    frac_n;
  logic                     clamp_n;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    offset  = $signed({v_q[WIDTH-1], v_q}) - V_MIN_S;
    idx_raw = offset[OFF_W-1:STEP_SHIFT];
    idx_n   = idx_raw[LUT_ADDR_BITS-1:0];
    frac_n  = offset[STEP_SHIFT-1:0];
    clamp_n = 1'b0;
    if (offset[OFF_W-1]) begin
      idx_n   = '0;
      frac_n  = '0;
      clamp_n = 1'b1;
    end else if (idx_raw >= LAST_RAW) begin
      idx_n   = LAST_IDX;
      frac_n  = '0;
      clamp_n = (offset > TOP_OFF);
    end
  end

  // Neighbouring entries; the last entry interpolates against itself.
  logic [WIDTH-1:0] lut_a, lut_b;
  always_comb begin
    lut_a = lut[r_q][idx_q];
    lut_b = (idx_q == LAST_IDX) ? lut_a : lut[r_q][idx_q + 1'b1];
  end

  // Shared multiplier: rate = a + floor((b - a) * frac / 2**STEP_SHIFT).
  logic signed [WIDTH:0]      diff;
  logic signed [PROD_W-1:0]   diff_ext, frac_ext, prod, interp, sum;
  logic [WIDTH-1:0]           rate;
  logic [NUM_RATES*WIDTH-1:0] rates_next;

  always_comb begin
    diff       = $signed({1'b0, b_q}) - $signed({1'b0, a_q});
    diff_ext   = {{STEP_SHIFT{diff[WIDTH]}}, diff};
    frac_ext   = $signed({{(PROD_W-STEP_SHIFT){1'b0}}, frac_q});
    prod       = diff_ext * frac_ext;
    interp     = prod >>> STEP_SHIFT;
    sum        = $signed({{(PROD_W-WIDTH){1'b0}}, a_q}) + interp;
    rate       = sum[WIDTH-1:0];
    rates_next = acc_q;
    rates_next[int'(r_q)*WIDTH +: WIDTH] = rate;
  end

  logic finish;
  assign finish = (state == S_CALC) && (r_q == LAST_RATE);

  logic [RATE_BITS-1:0]     cfg_sel;
  logic [LUT_ADDR_BITS-1:0] cfg_entry;
  logic                     cfg_ok;
  assign cfg_sel   = bus.cfg_addr[RATE_BITS+LUT_ADDR_BITS-1:LUT_ADDR_BITS];
  assign cfg_entry = bus.cfg_addr[LUT_ADDR_BITS-1:0];
  assign cfg_ok    = ((state == S_IDLE) || (state == S_DONE)) && ({1'b0, cfg_sel} < NUM_RATES_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      r_q           <= '0;
      out_rates_q   <= '0;
      out_tag_q     <= '0;
      out_clamped_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q <= bus.cfg_we && !cfg_ok;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            v_q   <= bus.in_voltage;
            tag_q <= bus.in_tag;
            state <= S_PREP;
          end
        end
        S_PREP: begin
          idx_q     <= idx_n;
          frac_q    <= frac_n;
          clamped_q <= clamp_n;
          r_q       <= '0;
          state     <= S_FETCH;
        end
        S_FETCH: begin
          a_q   <= lut_a;
          b_q   <= lut_b;
          state <= S_CALC;
        end
        S_CALC: begin
          acc_q <= rates_next;
          if (finish) begin
            out_rates_q   <= rates_next;
            out_tag_q     <= tag_q;
            out_clamped_q <= clamped_q;
            state         <= S_DONE;
          end else begin
            r_q   <= r_q + 1'b1;
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: table storage has no reset; contents survive rst_n and are reloaded only by cfg writes.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && cfg_ok) lut[cfg_sel][cfg_entry] <= bus.cfg_wdata;
  end

`ifdef HH_RATE_CLAMP_CNT_EN
  logic [15:0] clamp_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n)
      clamp_cnt_q <= '0;
    else if (finish && clamped_q && (clamp_cnt_q != 16'hFFFF))
      clamp_cnt_q <= clamp_cnt_q + 16'd1;
  end
  assign clamp_count = clamp_cnt_q;
`else
  assign clamp_count = '0;
`endif

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.out_rates   = out_rates_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_clamped = out_clamped_q;
  assign bus.cfg_busy    = (state == S_PREP) || (state == S_FETCH) || (state == S_CALC);
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_hh_rate_engine.sv
// Self-checking bench for hh_rate_engine: directed scenarios plus randomized jobs
// compared against an arithmetic LUT-interpolation model.
module tb_hh_rate_engine;
  localparam int W    = 16;
  localparam int NR   = 6;
  localparam int LAB  = 6;
  localparam int SS   = 9;
  localparam int VMIN = -20480;
  localparam int TB   = 4;
  localparam int ENT  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] clamp_count;

  hh_rate_if #(.WIDTH(W), .NUM_RATES(NR), .LUT_ADDR_BITS(LAB), .TAG_BITS(TB)) bus ();

  hh_rate_engine #(
    .WIDTH(W), .NUM_RATES(NR), .LUT_ADDR_BITS(LAB), .STEP_SHIFT(SS),
    .V_MIN(VMIN), .TAG_BITS(TB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clamp_count(clamp_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_lut [NR][ENT];
  int clamp_jobs = 0;
  int exp_rates [NR];
  int exp_tag;
  bit exp_cl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: map a voltage onto the table grid using plain integer arithmetic.
  function automatic void locate(input int v, output int idx, output int frac, output bit cl);
    int off;
    off = v - VMIN;
    if (off < 0) begin
      idx = 0; frac = 0; cl = 1'b1;
    end else begin
      idx = off / 512; frac = off % 512; cl = 1'b0;
      if (idx >= ENT - 1) begin
        cl = (off > (ENT - 1) * 512);
        idx = ENT - 1; frac = 0;
      end
    end
  endfunction

  function automatic int model_rate(input int r, input int idx, input int frac);
    int a, b, p, q;
    a = model_lut[r][idx];
    b = (idx == ENT - 1) ? a : model_lut[r][idx + 1];
    p = (b - a) * frac;
    q = p / 512;
    if (p < 0 && q * 512 != p) q = q - 1;
    return a + q;
  endfunction

  function automatic logic [15:0] rate_out(input int r);
    return bus.out_rates[r*W +: W];
  endfunction

  task automatic lut_write(input int rs, input int k, input int d);
    logic [2:0] rs3;
    logic [5:0] k6;
    bit ok;
    rs3 = rs[2:0];
    k6  = k[5:0];
    ok  = (rs < NR);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = {rs3, k6};
    bus.cfg_wdata = d[15:0];
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    if (ok) model_lut[rs][k] = d;
    check("cfg_err", bus.cfg_err, !ok);
  endtask

  task automatic send(input int v, input int tag);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_voltage = v[15:0];
    bus.in_tag     = tag[3:0];
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int v, input int tag, input int start);
    int idx, frac, lat;
    bit cl;
    locate(v, idx, frac, cl);
    for (int r = 0; r < NR; r++) exp_rates[r] = model_rate(r, idx, frac);
    exp_tag = tag;
    exp_cl  = cl;
    lat = start;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, 13);
    for (int r = 0; r < NR; r++) check($sformatf("rate%0d", r), rate_out(r), exp_rates[r]);
    check("out_tag", bus.out_tag, exp_tag);
    check("out_clamped", bus.out_clamped, exp_cl);
    if (cl) clamp_jobs++;
`ifdef HH_RATE_CLAMP_CNT_EN
    check("clamp_count", clamp_count, clamp_jobs);
`else
    check("clamp_count", clamp_count, 0);
`endif
  endtask

  task automatic hold_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
      for (int r = 0; r < NR; r++) check("hold_rate", rate_out(r), exp_rates[r]);
      check("hold_tag", bus.out_tag, exp_tag);
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("post_valid", bus.out_valid, 1'b0);
    check("post_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_out_rates"}, bus.out_rates, 0);
    check({tag, "_out_tag"}, bus.out_tag, 0);
    check({tag, "_out_clamped"}, bus.out_clamped, 1'b0);
    check({tag, "_cfg_busy"}, bus.cfg_busy, 1'b0);
    check({tag, "_cfg_err"}, bus.cfg_err, 1'b0);
    check({tag, "_clamp_count"}, clamp_count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    int v, tag, orphan;
    logic [15:0] raw;

    bus.in_valid = 1'b0; bus.in_voltage = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    reset_checks("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("por_release_in_ready", bus.in_ready, 1'b1);

    for (int r = 0; r < NR; r++)
      for (int k = 0; k < ENT; k++) lut_write(r, k, r * 1024 + k * 16);

    send(-20480, 3); wait_result(-20480, 3, 0);
    check("vmin_rate5", rate_out(5), 5120);
    release_result();

    send(-15104, 7); wait_result(-15104, 7, 0);
    check("mid_rate0", rate_out(0), 168);
    check("mid_rate5", rate_out(5), 5288);
    release_result();

    lut_write(0, 11, 150);
    send(-15104, 1); wait_result(-15104, 1, 0);
    check("down_rate0", rate_out(0), 155);
    release_result();

    send(-32768, 2); wait_result(-32768, 2, 0);
    check("low_rate0", rate_out(0), 0);
    check("low_clamped", bus.out_clamped, 1'b1);
    release_result();
    send(20000, 4); wait_result(20000, 4, 0);
    check("high_rate0", rate_out(0), 1008);
    check("high_clamped", bus.out_clamped, 1'b1);
    release_result();
    send(11776, 5); wait_result(11776, 5, 0);
    check("top_rate0", rate_out(0), 1008);
    check("top_clamped", bus.out_clamped, 1'b0);

    // Stall in DONE, then a request waiting on in_valid is taken right after the handshake.
    hold_check(5);
    bus.in_valid = 1'b1; bus.in_voltage = 16'(-9000); bus.in_tag = 4'd9;
    check("b2b_busy", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_ready", bus.in_ready, 1'b1);
    check("b2b_valid_low", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("b2b_accepted", bus.in_ready, 1'b0);
    wait_result(-9000, 9, 0);
    release_result();

    // Write during FETCH is rejected and the job sees the old entry.
    send(-15104, 6);
    @(posedge clk); #1;
    check("fetch_busy", bus.cfg_busy, 1'b1);
    bus.cfg_we = 1'b1; bus.cfg_addr = {3'd0, 6'd10}; bus.cfg_wdata = 16'd999;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    check("busy_cfg_err", bus.cfg_err, 1'b1);
    @(posedge clk); #1;
    check("busy_cfg_err_pulse", bus.cfg_err, 1'b0);
    wait_result(-15104, 6, 3);
    check("busy_rate0", rate_out(0), 155);
    release_result();

    lut_write(6, 10, 999);
    send(-15104, 8); wait_result(-15104, 8, 0);
    release_result();

    // Reset while in CALC aborts the job; tables survive.
    send(-15104, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("calc_busy", bus.cfg_busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    clamp_jobs = 0;
    reset_checks("mid");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_release_in_ready", bus.in_ready, 1'b1);
    orphan = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) orphan++;
    end
    check("no_orphan_result", orphan, 0);
    send(-15104, 11); wait_result(-15104, 11, 0);
    release_result();

    send(-32768, 1); wait_result(-32768, 1, 0); release_result();
    send(30000, 2);  wait_result(30000, 2, 0);  release_result();
    send(-25000, 3); wait_result(-25000, 3, 0); release_result();
`ifdef HH_RATE_CLAMP_CNT_EN
    check("three_clamped", clamp_count, 3);
`endif

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1)
        lut_write($urandom_range(0, 7), $urandom_range(0, ENT - 1), $urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) begin
        raw = 16'($urandom);
        v = int'($signed(raw));
      end else begin
        v = VMIN + $urandom_range(0, 32767);
      end
      tag = $urandom_range(0, 15);
      send(v, tag);
      wait_result(v, tag, 0);
      hold_check($urandom_range(0, 3));
      release_result();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
